// File: rtl/add_nrm_acc_if.sv
`default_nettype none
// ============================================================================
//  Module   : add_nrm_acc_if
//  Purpose  : Beat-input / frame-result bundle for the add_nrm_acc streaming
//             accumulator. Names are written from the accumulator's side.
//  Signals  : i_valid/o_ready/i_first/i_last/i_op/i_scale - input beat stream
//             o_valid/i_ready/o_sum/o_scale/o_ovf         - frame result
//  Modports : slave  - the accumulator
//             master - the producer/consumer around it
//  Revision : 1.0  initial release
// ============================================================================
interface add_nrm_acc_if #(
    parameter int INT_W   = 24,
    parameter int SCALE_W = 8
) ();
    logic               i_valid;
    logic               o_ready;
    logic               i_first;
    logic               i_last;
    logic [INT_W-1:0]   i_op;
    logic [SCALE_W-1:0] i_scale;
    logic               o_valid;
    logic               i_ready;
    logic [INT_W-1:0]   o_sum;
    logic [SCALE_W-1:0] o_scale;
    logic               o_ovf;

    modport slave (
        input  i_valid, i_first, i_last, i_op, i_scale, i_ready,
        output o_ready, o_valid, o_sum, o_scale, o_ovf
    );

    modport master (
        output i_valid, i_first, i_last, i_op, i_scale, i_ready,
        input  o_ready, o_valid, o_sum, o_scale, o_ovf
    );
endinterface
`default_nettype wire

// File: rtl/add_nrm_acc.sv
`default_nettype none
// ============================================================================
//  Module   : add_nrm_acc
//  Purpose  : Streaming accumulator of scaled two's-complement values
//             (value = op * 2^scale). Every accepted beat is aligned, added,
//             normalised and rounded into a registered accumulator; one
//             normalised (sum, scale, ovf) result is emitted per frame
//             through a valid/ready output register.
//  Ports    : i_clk  - clock, rising edge
//             i_rst  - asynchronous reset, active-high
//             bus    - add_nrm_acc_if.slave (beat input + result output)
//  Revision : 1.0  initial release
// ============================================================================
module add_nrm_acc #(
    parameter int INT_W    = 24,
    parameter int SCALE_W  = 8,
    parameter int GRD_W    = 3,
    parameter int RND_MODE = 0
) (
    input  wire logic    i_clk,
    input  wire logic    i_rst,
    add_nrm_acc_if.slave bus
);
    localparam int N_W = INT_W + GRD_W;   // operand extended by guard bits
    localparam int S_W = N_W + 1;         // sum with one carry bit
    localparam int E_W = SCALE_W + 2;     // scale with room for two increments

    localparam logic [E_W-1:0]   c_scale_max = E_W'((1 << SCALE_W) - 1);
    localparam logic [E_W-1:0]   c_one       = E_W'(1);
    localparam logic [INT_W-1:0] c_pos_max   = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] c_neg_max   = {1'b1, {(INT_W-1){1'b0}}};
    localparam logic [INT_W-1:0] c_half      = {2'b01, {(INT_W-2){1'b0}}};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [INT_W-1:0]   r_acc;
    logic [SCALE_W-1:0] r_acc_scale;
    logic               r_acc_ovf;
    logic               r_valid;
    logic [INT_W-1:0]   r_sum;
    logic [SCALE_W-1:0] r_scale;
    logic               r_ovf;

    logic               w_fire, w_open, w_load_acc, w_load_out;
    logic [INT_W-1:0]   w_base_op;
    logic [SCALE_W-1:0] w_base_scale;
    logic               w_base_ovf;

    logic [N_W-1:0]     w_xa, w_xb, w_big, w_small, w_shr, w_aln;
    logic [SCALE_W-1:0] w_big_scale, w_diff;
    logic               w_lost;
    logic [S_W-1:0]     w_sum, w_nrm;
    logic [E_W-1:0]     w_sc, w_sc_fin;
    logic [INT_W-1:0]   w_int, w_res;
    logic [GRD_W-1:0]   w_grd;
    logic               w_up, w_sat;
    logic [INT_W-1:0]   w_step_op;
    logic [SCALE_W-1:0] w_step_scale;
    logic               w_step_ovf;

    assign bus.o_ready = ~r_valid | bus.i_ready;
    assign w_fire      = bus.i_valid & bus.o_ready;

    // A beat in IDLE opens a frame even without i_first; i_first inside a
    // frame restarts it. Either way the beat is added to zero at scale 0.
    assign w_open       = (r_state == S_IDLE) | bus.i_first;
    assign w_base_op    = w_open ? '0 : r_acc;
    assign w_base_scale = w_open ? '0 : r_acc_scale;
    assign w_base_ovf   = w_open ? 1'b0 : r_acc_ovf;

    // Align, add, normalise, round, saturate.
    always_comb begin : p_step
        w_xa = {w_base_op, {GRD_W{1'b0}}};
        w_xb = {bus.i_op,  {GRD_W{1'b0}}};
        if (w_base_scale >= bus.i_scale) begin
            w_big_scale = w_base_scale;
            w_diff      = w_base_scale - bus.i_scale;
            w_big       = w_xa;
            w_small     = w_xb;
        end else begin
            w_big_scale = bus.i_scale;
            w_diff      = bus.i_scale - w_base_scale;
            w_big       = w_xb;
            w_small     = w_xa;
        end
        // Bits shifted past the guard field collapse into the sticky LSB.
        w_shr  = $signed(w_small) >>> w_diff;
        w_lost = |(w_small & ~({N_W{1'b1}} << w_diff));
        w_aln  = {w_shr[N_W-1:1], w_shr[0] | w_lost};
        w_sum  = {w_big[N_W-1], w_big} + {w_aln[N_W-1], w_aln};

        w_nrm = w_sum;
        w_sc  = {2'b00, w_big_scale};
        if (w_sum == '0) begin
            w_sc = '0;
        end else if (w_sum[S_W-1] != w_sum[S_W-2]) begin
            // Carry into the sign: one arithmetic right shift, sticky kept.
            w_nrm = {w_sum[S_W-1], w_sum[S_W-1:2], w_sum[1] | w_sum[0]};
            w_sc  = w_sc + c_one;
        end else begin
            // Left-normalise, but never below scale 0 (gradual underflow).
            for (int k = 0; k < S_W - 2; k++) begin
                if ((w_nrm[S_W-2] == w_nrm[S_W-3]) && (w_sc != '0)) begin
                    w_nrm = w_nrm << 1;
                    w_sc  = w_sc - c_one;
                end
            end
        end

        w_int = w_nrm[S_W-2:GRD_W];
        w_grd = w_nrm[GRD_W-1:0];
        if (RND_MODE == 0) begin
            w_up = w_grd[GRD_W-1] & ((|w_grd[GRD_W-2:0]) | w_int[0]);
        end else begin
            w_up = 1'b0;
        end
        w_res    = w_int + INT_W'(w_up);
        w_sc_fin = w_sc;
        if (w_up && (w_int == c_pos_max)) begin
            // Rounding wrapped +max to 1000..0: renormalise by one.
            w_res    = c_half;
            w_sc_fin = w_sc + c_one;
        end

        w_sat = (w_sc_fin > c_scale_max);
        if (w_sat) begin
            w_step_op    = w_nrm[S_W-1] ? c_neg_max : c_pos_max;
            w_step_scale = c_scale_max[SCALE_W-1:0];
        end else begin
            w_step_op    = w_res;
            w_step_scale = w_sc_fin[SCALE_W-1:0];
        end
        w_step_ovf = w_base_ovf | w_sat;
    end

    // Both states take the same transitions; the state only decides whether
    // the accumulator or zero feeds the next beat.
    always_comb begin : p_fsm
        w_state_nxt = r_state;
        w_load_acc  = 1'b0;
        w_load_out  = 1'b0;
        case (r_state)
            S_IDLE, S_ACC: begin
                if (w_fire) begin
                    if (bus.i_last) begin
                        w_load_out  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_load_acc  = 1'b1;
                        w_state_nxt = S_ACC;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_acc_scale <= '0;
            r_acc_ovf   <= 1'b0;
            r_valid     <= 1'b0;
            r_sum       <= '0;
            r_scale     <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_acc) begin
                r_acc       <= w_step_op;
                r_acc_scale <= w_step_scale;
                r_acc_ovf   <= w_step_ovf;
            end
            if (w_load_out) begin
                r_valid <= 1'b1;
                r_sum   <= w_step_op;
                r_scale <= w_step_scale;
                r_ovf   <= w_step_ovf;
            end else if (bus.i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.o_valid = r_valid;
    assign bus.o_sum   = r_sum;
    assign bus.o_scale = r_scale;
    assign bus.o_ovf   = r_ovf;
endmodule
`default_nettype wire
